icache_dm: RTL

- Direct-mapped instruction cache feeding the decode stage's instruction input.
- Responder side of the fetch interface. fc presents a PC plus a request. The cache returns the instruction word with a one-cycle valid strobe (Icache_data_valid_o) that ID qualifies its instruction with.
- On a miss, refills one line from the memory port over a per-beat req/ack handshake, holding fc stalled through busy.

---
 rtl/icache_dm.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache sitting between fetch control and decode.
// Hits return the addressed word one cycle after the request; misses refill
// a whole line from the memory port one beat at a time, with busy held high
// so fetch control keeps its PC and request stable until the line is in.
module icache_dm #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fc_pc_i,
  input  logic              fc_req_i,
  input  logic              fc_jump_flag_i,
  input  logic              fc_fence_i_i,
  output logic [31:0]       Icache_inst_o,
  output logic              Icache_data_valid_o,
  output logic              Icache_busy_o,
  output logic              Icache_mem_req_o,
  output logic [ADDR_W-1:0] Icache_mem_addr_o,
  input  logic              mem_Icache_ack_i,
  input  logic [31:0]       mem_Icache_rdata_i
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int SET_BITS  = $clog2(SETS);
  localparam int TAG_W     = ADDR_W - SET_BITS - WORD_BITS - 2;
  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_DONE
  } state_t;

  state_t                state_reg;
  logic [31:0]           inst_reg;
  logic                  data_valid_reg;
  logic                  busy_reg;
  logic                  mem_req_reg;
  logic [ADDR_W-1:0]     mem_addr_reg;
  logic                  fence_pending_reg;
  logic                  cancel_reg;
  logic [WORD_BITS-1:0]  beat_reg;
  logic [TAG_W-1:0]      lat_tag_reg;
  logic [SET_BITS-1:0]   lat_set_reg;
  logic [WORD_BITS-1:0]  lat_word_reg;
  logic [SETS-1:0]       valid_reg;

  // Storage: tags and line data are never reset; the valid bits guard them.
  logic [31:0]           data_mem [SETS*LINE_WORDS];
  logic [TAG_W-1:0]      tag_mem  [SETS];

  // Request address fields; the byte offset bits carry no information.
  logic [WORD_BITS-1:0]  req_word;
  logic [SET_BITS-1:0]   req_set;
  logic [TAG_W-1:0]      req_tag;
  logic                  unused_pc_bits;

  assign req_word       = fc_pc_i[WORD_BITS+1:2];
  assign req_set        = fc_pc_i[WORD_BITS+SET_BITS+1:WORD_BITS+2];
  assign req_tag        = fc_pc_i[ADDR_W-1:WORD_BITS+SET_BITS+2];
  assign unused_pc_bits = ^fc_pc_i[1:0];

  logic hit;
  logic fence_apply;
  logic refill_we;
  logic install;

  assign hit         = valid_reg[req_set] && (tag_mem[req_set] == req_tag);
  assign fence_apply = (state_reg == S_IDLE) && (fc_fence_i_i || fence_pending_reg);
  assign refill_we   = (state_reg == S_REFILL) && mem_Icache_ack_i;
  assign install     = refill_we && (beat_reg == LAST_BEAT);

  // Refill writes: each accepted beat lands in its word slot, the tag on the last beat.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      data_mem[{lat_set_reg, beat_reg}] <= mem_Icache_rdata_i;
      if (beat_reg == LAST_BEAT) begin
        tag_mem[lat_set_reg] <= lat_tag_reg;
      end
    end
  end

  // Per-set valid bits: fence wipes every line, line install marks its own set.
  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (fence_apply) begin
          valid_reg[gi] <= 1'b0;
        end else if (install && (lat_set_reg == SET_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Control FSM with registered response, busy and refill-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      inst_reg          <= '0;
      data_valid_reg    <= 1'b0;
      busy_reg          <= 1'b0;
      mem_req_reg       <= 1'b0;
      mem_addr_reg      <= '0;
      fence_pending_reg <= 1'b0;
      cancel_reg        <= 1'b0;
      beat_reg          <= '0;
      lat_tag_reg       <= '0;
      lat_set_reg       <= '0;
      lat_word_reg      <= '0;
    end else begin
      // The response is a single-cycle pulse unless re-armed below.
      inst_reg       <= '0;
      data_valid_reg <= 1'b0;

      // A redirect or fence that arrives while busy is remembered for later.
      if (busy_reg && fc_jump_flag_i) begin
        cancel_reg <= 1'b1;
      end
      if (busy_reg && fc_fence_i_i) begin
        fence_pending_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (fence_apply) begin
            fence_pending_reg <= 1'b0;
          end else if (fc_req_i && !fc_jump_flag_i) begin
            if (hit) begin
              inst_reg       <= data_mem[{req_set, req_word}];
              data_valid_reg <= 1'b1;
            end else begin
              lat_tag_reg  <= req_tag;
              lat_set_reg  <= req_set;
              lat_word_reg <= req_word;
              cancel_reg   <= 1'b0;
              beat_reg     <= '0;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= {req_tag, req_set, {WORD_BITS{1'b0}}, 2'b00};
              busy_reg     <= 1'b1;
              state_reg    <= S_REFILL;
            end
          end
        end

        S_REFILL: begin
          if (mem_Icache_ack_i) begin
            // Beat counter wraps back to zero after the last beat.
            beat_reg     <= beat_reg + WORD_BITS'(1);
            mem_addr_reg <= mem_addr_reg + ADDR_W'(4);
            if (beat_reg == LAST_BEAT) begin
              mem_req_reg <= 1'b0;
              state_reg   <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // A redirect seen in this very cycle also suppresses the response.
          if (!(cancel_reg || fc_jump_flag_i)) begin
            inst_reg       <= data_mem[{lat_set_reg, lat_word_reg}];
            data_valid_reg <= 1'b1;
          end
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          busy_reg    <= 1'b0;
          mem_req_reg <= 1'b0;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

  assign Icache_inst_o       = inst_reg;
  assign Icache_data_valid_o = data_valid_reg;
  assign Icache_busy_o       = busy_reg;
  assign Icache_mem_req_o    = mem_req_reg;
  assign Icache_mem_addr_o   = mem_addr_reg;

endmodule
